// File: rtl/vga_ball_raster_if.sv
// Avalon-MM slave bus bundle for the ball raster register file.
interface vga_ball_raster_if;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport slave (
    input  chipselect,
    input  write,
    input  read,
    input  address,
    input  writedata,
    output readdata
  );

  modport master (
    output chipselect,
    output write,
    output read,
    output address,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/vga_ball_raster.sv
// VGA raster engine: 640x480@60 timing from a 50 MHz clock, filled ball on a background.
// Position/colour are written to staged registers and copied live once per frame at vblank.
module vga_ball_raster #(
  parameter int unsigned RADIUS     = 16,
  parameter logic [23:0] BALL_RGB   = 24'hFFFFFF,
  // Raster geometry in hcount (half-pixel) and line units
  parameter int unsigned HActive    = 1280,
  parameter int unsigned HSyncStart = 1312,
  parameter int unsigned HSyncEnd   = 1504,
  parameter int unsigned HTotal     = 1600,
  parameter int unsigned VActive    = 480,
  parameter int unsigned VSyncStart = 490,
  parameter int unsigned VSyncEnd   = 492,
  parameter int unsigned VTotal     = 525
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vga_ball_raster_if.slave        avs,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_clk,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n,
  output logic                    vga_sync_n
);

  localparam logic [10:0] HLast    = 11'(HTotal - 1);
  localparam logic [9:0]  VLast    = 10'(VTotal - 1);
  localparam logic [10:0] HActW    = 11'(HActive);
  localparam logic [10:0] HSyncS   = 11'(HSyncStart);
  localparam logic [10:0] HSyncE   = 11'(HSyncEnd);
  localparam logic [9:0]  VActW    = 10'(VActive);
  localparam logic [9:0]  VSyncS   = 10'(VSyncStart);
  localparam logic [9:0]  VSyncE   = 10'(VSyncEnd);
  localparam logic [21:0] RadiusSq = 22'(RADIUS * RADIUS);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [6:0]  frame_q, frame_d;

  // Staged (bus-visible) and live (displayed) copies of the programmable state
  logic [23:0] bg_stg_q, bg_stg_d, bg_live_q;
  logic [9:0]  x_stg_q, x_stg_d, x_live_q;
  logic [8:0]  y_stg_q, y_stg_d, y_live_q;
  logic [7:0]  readdata_q, readdata_d;

  logic        wr_en, rd_en, copy_en, vblank, active, in_hsync, in_vsync, in_ball;
  logic [23:0] pix_rgb;

  assign wr_en   = avs.chipselect & avs.write;
  assign rd_en   = avs.chipselect & avs.read;
  assign copy_en = (hcount_q == 11'd0) && (vcount_q == VActW);
  assign vblank  = (vcount_q >= VActW);
  assign active  = (hcount_q < HActW) && (vcount_q < VActW);
  assign in_hsync = (hcount_q >= HSyncS) && (hcount_q < HSyncE);
  assign in_vsync = (vcount_q >= VSyncS) && (vcount_q < VSyncE);

  // Raster counters: hcount wraps into vcount, vcount wraps into frame
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    if (hcount_q == HLast) begin
      hcount_d = '0;
      vcount_d = vcount_q + 10'd1;
      if (vcount_q == VLast) begin
        vcount_d = '0;
        frame_d  = frame_q + 7'd1;
      end
    end
  end

  // Counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      frame_q  <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_q  <= frame_d;
    end
  end

  // Bus writes land in the staged copy; address 7 is read-only
  always_comb begin
    bg_stg_d = bg_stg_q;
    x_stg_d  = x_stg_q;
    y_stg_d  = y_stg_q;
    if (wr_en) begin
      case (avs.address)
        3'd0:    bg_stg_d[23:16] = avs.writedata;
        3'd1:    bg_stg_d[15:8]  = avs.writedata;
        3'd2:    bg_stg_d[7:0]   = avs.writedata;
        3'd3:    x_stg_d[7:0]    = avs.writedata;
        3'd4:    x_stg_d[9:8]    = avs.writedata[1:0];
        3'd5:    y_stg_d[7:0]    = avs.writedata;
        3'd6:    y_stg_d[8]      = avs.writedata[0];
        default: ;
      endcase
    end
  end

  // Read mux returns staged values; status reflects the current raster position
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (avs.address)
        3'd0:    readdata_d = bg_stg_q[23:16];
        3'd1:    readdata_d = bg_stg_q[15:8];
        3'd2:    readdata_d = bg_stg_q[7:0];
        3'd3:    readdata_d = x_stg_q[7:0];
        3'd4:    readdata_d = {6'b0, x_stg_q[9:8]};
        3'd5:    readdata_d = y_stg_q[7:0];
        3'd6:    readdata_d = {7'b0, y_stg_q[8]};
        default: readdata_d = {frame_q, vblank};
      endcase
    end
  end

  // Staged registers and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_stg_q   <= 24'h000080;
      x_stg_q    <= 10'd320;
      y_stg_q    <= 9'd240;
      readdata_q <= '0;
    end else begin
      bg_stg_q   <= bg_stg_d;
      x_stg_q    <= x_stg_d;
      y_stg_q    <= y_stg_d;
      readdata_q <= readdata_d;
    end
  end

  // Live copy: sampled from pre-write staged values on the single vblank copy cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_live_q <= 24'h000080;
      x_live_q  <= 10'd320;
      y_live_q  <= 9'd240;
    end else if (copy_en) begin
      bg_live_q <= bg_stg_q;
      x_live_q  <= x_stg_q;
      y_live_q  <= y_stg_q;
    end
  end

  assign avs.readdata = readdata_q;

  // Ball membership; squaring magnitudes keeps the multipliers unsigned
  logic signed [10:0] dx, dy;
  logic [9:0]         adx, ady;
  logic [20:0]        dx2, dy2;
  logic [21:0]        dist2;

  always_comb begin
    dx      = $signed({1'b0, hcount_q[10:1]}) - $signed({1'b0, x_live_q});
    dy      = $signed({1'b0, vcount_q}) - $signed({2'b0, y_live_q});
    adx     = dx[10] ? 10'(-dx) : 10'(dx);
    ady     = dy[10] ? 10'(-dy) : 10'(dy);
    dx2     = 21'(adx) * 21'(adx);
    dy2     = 21'(ady) * 21'(ady);
    dist2   = 22'(dx2) + 22'(dy2);
    in_ball = (dist2 <= RadiusSq);
    pix_rgb = '0;
    if (active) pix_rgb = in_ball ? BALL_RGB : bg_live_q;
  end

  // Output stage: every vga_* signal registered from the same count so they stay aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_clk     <= 1'b0;
      vga_hs      <= 1'b0;
      vga_vs      <= 1'b0;
      vga_blank_n <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= pix_rgb;
      vga_clk               <= hcount_q[0];
      vga_hs                <= ~in_hsync;
      vga_vs                <= ~in_vsync;
      vga_blank_n           <= active;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule
